ctrl_decode_stage: RTL and testbench

Registered, parametrised successor to the single-cycle control unit, for the multi-cycle RV32IM core. Decodes a raw instruction into a control bundle and holds it in a one-entry valid/ready pipeline register between fetch and execute. Supports synchronous flush and illegal-instruction flagging. Models multi-cycle M-extension occupancy with a latency counter.

---
 rtl/ctrl_decode_stage.sv | 265 ++++++++++++++++++++++++++
 tb/tb_ctrl_decode_stage.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_decode_stage.sv
// Registered RV32IM control decode stage: one-entry valid/ready holding register with flush,
// illegal-instruction flagging and M-extension busy modelling (M decode enabled by RV32M_EN).
module ctrl_decode_stage #(
   parameter int XLEN       = 32,
   parameter int ALU_OP_W   = 4,
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 33
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_instr,
   input  logic [XLEN-1:0]     in_pc,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [31:0]         out_instr,
   output logic [XLEN-1:0]     out_pc,
   output logic [2:0]          out_funct3,
   output logic                rd_wen,
   output logic                mem_rd,
   output logic                mem_wr,
   output logic                branch,
   output logic                jump,
   output logic                alu_a_pc,
   output logic                alu_b_imm,
   output logic [2:0]          imm_sel,
   output logic [1:0]          wb_sel,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                is_muldiv,
   output logic                illegal,
   output logic                mdu_busy
);

   // state    | meaning
   // EMPTY    | nothing held, ready for a new instruction
   // FULL     | decoded bundle presented downstream
   // WAIT     | M-extension op occupying the unit, counting down its latency

   localparam int LAT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

   localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(0);
   localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(1);
   localparam logic [ALU_OP_W-1:0] ALU_AND   = ALU_OP_W'(2);
   localparam logic [ALU_OP_W-1:0] ALU_OR    = ALU_OP_W'(3);
   localparam logic [ALU_OP_W-1:0] ALU_XOR   = ALU_OP_W'(4);
   localparam logic [ALU_OP_W-1:0] ALU_SLL   = ALU_OP_W'(5);
   localparam logic [ALU_OP_W-1:0] ALU_SRL   = ALU_OP_W'(6);
   localparam logic [ALU_OP_W-1:0] ALU_SRA   = ALU_OP_W'(7);
   localparam logic [ALU_OP_W-1:0] ALU_SLT   = ALU_OP_W'(8);
   localparam logic [ALU_OP_W-1:0] ALU_SLTU  = ALU_OP_W'(9);
   localparam logic [ALU_OP_W-1:0] ALU_PASSB = ALU_OP_W'(15);

   typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_WAIT} state_t;

   typedef struct packed {
      logic [31:0]         instr;
      logic [XLEN-1:0]     pc;
      logic                rd_wen;
      logic                mem_rd;
      logic                mem_wr;
      logic                branch;
      logic                jump;
      logic                alu_a_pc;
      logic                alu_b_imm;
      logic [2:0]          imm_sel;
      logic [1:0]          wb_sel;
      logic [ALU_OP_W-1:0] alu_op;
      logic                is_muldiv;
      logic                illegal;
   } bundle_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_load;
   bundle_t          bundle_q, bundle_d, dec;
   logic [6:0]       dec_opc, dec_f7;
   logic [2:0]       dec_f3;
   logic [31:0]      lat;
   logic             go_wait, accept;

   function automatic logic [ALU_OP_W-1:0] alu_from_f3(input logic [2:0] f3, input logic alt);
      logic [ALU_OP_W-1:0] op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   assign dec_opc = in_instr[6:0];
   assign dec_f3  = in_instr[14:12];
   assign dec_f7  = in_instr[31:25];

   always_comb begin
      dec       = '0;
      dec.instr = in_instr;
      dec.pc    = in_pc;
      case (dec_opc)
         7'b0110011: begin
            dec.rd_wen = 1'b1;
            case (dec_f7)
               7'b0000000: dec.alu_op = alu_from_f3(dec_f3, 1'b0);
               7'b0100000: begin
                  if (dec_f3 == 3'b000 || dec_f3 == 3'b101) dec.alu_op = alu_from_f3(dec_f3, 1'b1);
                  else                                      dec.illegal = 1'b1;
               end
`ifdef RV32M_EN
               7'b0000001: dec.is_muldiv = 1'b1;
`endif
               default: dec.illegal = 1'b1;
            endcase
         end
         7'b0010011: begin
            dec.rd_wen    = 1'b1;
            dec.alu_b_imm = 1'b1;
            dec.alu_op    = alu_from_f3(dec_f3, (dec_f3 == 3'b101) && dec_f7[5]);
            if (dec_f3 == 3'b001 && dec_f7 != 7'b0000000) dec.illegal = 1'b1;
            if (dec_f3 == 3'b101 && dec_f7 != 7'b0000000 && dec_f7 != 7'b0100000) dec.illegal = 1'b1;
         end
         7'b0000011: begin
            dec.rd_wen    = 1'b1;
            dec.mem_rd    = 1'b1;
            dec.alu_b_imm = 1'b1;
            dec.wb_sel    = 2'd1;
         end
         7'b0100011: begin
            dec.mem_wr    = 1'b1;
            dec.alu_b_imm = 1'b1;
            dec.imm_sel   = 3'd1;
         end
         7'b1100011: begin
            dec.branch  = 1'b1;
            dec.alu_op  = ALU_SUB;
            dec.imm_sel = 3'd2;
            if (dec_f3 == 3'b010 || dec_f3 == 3'b011) dec.illegal = 1'b1;
         end
         7'b0110111: begin
            dec.rd_wen    = 1'b1;
            dec.alu_b_imm = 1'b1;
            dec.alu_op    = ALU_PASSB;
            dec.imm_sel   = 3'd3;
         end
         7'b0010111: begin
            dec.rd_wen    = 1'b1;
            dec.alu_a_pc  = 1'b1;
            dec.alu_b_imm = 1'b1;
            dec.imm_sel   = 3'd3;
         end
         7'b1101111: begin
            dec.rd_wen   = 1'b1;
            dec.jump     = 1'b1;
            dec.alu_a_pc = 1'b1;
            dec.imm_sel  = 3'd4;
            dec.wb_sel   = 2'd2;
         end
         7'b1100111: begin
            dec.rd_wen    = 1'b1;
            dec.jump      = 1'b1;
            dec.alu_b_imm = 1'b1;
            dec.wb_sel    = 2'd2;
            if (dec_f3 != 3'b000) dec.illegal = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
      // An illegal bundle still flows downstream, but must never cause side effects.
      if (dec.illegal) begin
         dec.rd_wen    = 1'b0;
         dec.mem_rd    = 1'b0;
         dec.mem_wr    = 1'b0;
         dec.branch    = 1'b0;
         dec.jump      = 1'b0;
         dec.is_muldiv = 1'b0;
      end
   end

   assign lat      = dec_f3[2] ? 32'(DIV_CYCLES) : 32'(MUL_CYCLES);
   assign go_wait  = dec.is_muldiv && (lat != 32'd0);
   assign cnt_load = CNT_W'(lat - 32'd1);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bundle_d  = bundle_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      mdu_busy  = 1'b0;
      case (state_q)
         ST_EMPTY: in_ready = 1'b1;
         ST_FULL: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
         end
         ST_WAIT: begin
`ifdef RV32M_EN
            mdu_busy = 1'b1;
`endif
         end
         default: ;
      endcase
      if (flush) begin
         in_ready  = 1'b0;
         out_valid = 1'b0;
      end
      accept = in_valid && in_ready;

      if (flush) begin
         state_d = ST_EMPTY;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_EMPTY, ST_FULL: begin
               if (accept) begin
                  bundle_d = dec;
                  state_d  = go_wait ? ST_WAIT : ST_FULL;
                  cnt_d    = go_wait ? cnt_load : '0;
               end else if (state_q == ST_FULL && out_ready) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_WAIT: begin
               if (cnt_q == '0) state_d = ST_FULL;
               else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_EMPTY;
         cnt_q    <= '0;
         bundle_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bundle_q <= bundle_d;
      end
   end

   assign out_instr  = bundle_q.instr;
   assign out_pc     = bundle_q.pc;
   assign out_funct3 = bundle_q.instr[14:12];
   assign rd_wen     = bundle_q.rd_wen;
   assign mem_rd     = bundle_q.mem_rd;
   assign mem_wr     = bundle_q.mem_wr;
   assign branch     = bundle_q.branch;
   assign jump       = bundle_q.jump;
   assign alu_a_pc   = bundle_q.alu_a_pc;
   assign alu_b_imm  = bundle_q.alu_b_imm;
   assign imm_sel    = bundle_q.imm_sel;
   assign wb_sel     = bundle_q.wb_sel;
   assign alu_op     = bundle_q.alu_op;
   assign is_muldiv  = bundle_q.is_muldiv;
   assign illegal    = bundle_q.illegal;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Randomized self-checking bench for ctrl_decode_stage against an instruction-level reference model.
module tb_ctrl_decode_stage;

`ifdef RV32M_EN
   localparam bit M_EN = 1'b1;
`else
   localparam bit M_EN = 1'b0;
`endif
   localparam int MUL_LAT = 2;
   localparam int DIV_LAT = 33;

   typedef struct packed {
      logic       rd_wen, mem_rd, mem_wr, branch, jump, alu_a_pc, alu_b_imm;
      logic [2:0] imm_sel;
      logic [1:0] wb_sel;
      logic [3:0] alu_op;
      logic       is_muldiv, illegal;
   } ctl_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr, out_pc;
   logic [2:0]  out_funct3, imm_sel;
   logic        rd_wen, mem_rd, mem_wr, branch, jump, alu_a_pc, alu_b_imm;
   logic [1:0]  wb_sel;
   logic [3:0]  alu_op;
   logic        is_muldiv, illegal, mdu_busy;
   ctl_t        obs;

   int checks = 0;
   int passed = 0;

   ctrl_decode_stage #(.XLEN(32), .ALU_OP_W(4), .MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc), .out_funct3(out_funct3), .rd_wen(rd_wen),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .branch(branch), .jump(jump), .alu_a_pc(alu_a_pc),
      .alu_b_imm(alu_b_imm), .imm_sel(imm_sel), .wb_sel(wb_sel), .alu_op(alu_op),
      .is_muldiv(is_muldiv), .illegal(illegal), .mdu_busy(mdu_busy)
   );

   always #5 clk = ~clk;

   assign obs = {rd_wen, mem_rd, mem_wr, branch, jump, alu_a_pc, alu_b_imm,
                 imm_sel, wb_sel, alu_op, is_muldiv, illegal};

   // Expected control bundle for an instruction word, plus a mask of the fields that are defined.
   function automatic void ref_decode(input logic [31:0] ins, output ctl_t e, output ctl_t m);
      logic [6:0] op, f7;
      logic [2:0] f3;
      logic [3:0] base;
      bit legal, md, imm_care;
      op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
      e = '0; legal = 1; md = 0; imm_care = 1;
      case (f3)
         3'd0: base = 4'd0;  3'd1: base = 4'd5;  3'd2: base = 4'd8;  3'd3: base = 4'd9;
         3'd4: base = 4'd4;  3'd5: base = 4'd6;  3'd6: base = 4'd3;  default: base = 4'd2;
      endcase
      case (op)
         7'h33: begin
            e.rd_wen = 1; imm_care = 0;
            if (f7 == 7'h00) e.alu_op = base;
            else if (f7 == 7'h20 && f3 == 3'd0) e.alu_op = 4'd1;
            else if (f7 == 7'h20 && f3 == 3'd5) e.alu_op = 4'd7;
            else if (f7 == 7'h01 && M_EN) begin md = 1; e.is_muldiv = 1; end
            else legal = 0;
         end
         7'h13: begin
            e.rd_wen = 1; e.alu_b_imm = 1;
            e.alu_op = (f3 == 3'd5 && f7 == 7'h20) ? 4'd7 : base;
            if (f3 == 3'd1 && f7 != 7'h00) legal = 0;
            if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) legal = 0;
         end
         7'h03: begin e.rd_wen = 1; e.mem_rd = 1; e.alu_b_imm = 1; e.wb_sel = 2'd1; end
         7'h23: begin e.mem_wr = 1; e.alu_b_imm = 1; e.imm_sel = 3'd1; end
         7'h63: begin
            e.branch = 1; e.alu_op = 4'd1; e.imm_sel = 3'd2;
            if (f3 == 3'd2 || f3 == 3'd3) legal = 0;
         end
         7'h37: begin e.rd_wen = 1; e.alu_b_imm = 1; e.alu_op = 4'd15; e.imm_sel = 3'd3; end
         7'h17: begin e.rd_wen = 1; e.alu_a_pc = 1; e.alu_b_imm = 1; e.imm_sel = 3'd3; end
         7'h6F: begin e.rd_wen = 1; e.jump = 1; e.alu_a_pc = 1; e.imm_sel = 3'd4; e.wb_sel = 2'd2; end
         7'h67: begin
            e.rd_wen = 1; e.jump = 1; e.alu_b_imm = 1; e.wb_sel = 2'd2;
            if (f3 != 3'd0) legal = 0;
         end
         default: legal = 0;
      endcase
      if (!legal) begin
         e.rd_wen = 0; e.mem_rd = 0; e.mem_wr = 0; e.branch = 0; e.jump = 0; e.is_muldiv = 0;
         e.illegal = 1;
      end
      m = '0;
      m.rd_wen = 1; m.mem_rd = 1; m.mem_wr = 1; m.branch = 1; m.jump = 1;
      m.is_muldiv = 1; m.illegal = 1;
      if (legal && !md) begin
         m.alu_a_pc = 1; m.alu_b_imm = 1; m.wb_sel = 2'b11; m.alu_op = 4'hF;
         m.imm_sel = imm_care ? 3'b111 : 3'b000;
      end
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [6:0] ops [10];
      logic [6:0] f7;
      logic [31:0] r, ins;
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};
      r = $urandom();
      case ($urandom_range(0, 3))
         0: f7 = 7'h00;
         1: f7 = 7'h20;
         2: f7 = 7'h01;
         default: f7 = 7'($urandom());
      endcase
      ins = {f7, r[24:7], ops[$urandom_range(0, 9)]};
      if (ins[6:0] == 7'h67 && $urandom_range(0, 1) == 1) ins[14:12] = 3'd0;
      if ($urandom_range(0, 15) == 0) ins = $urandom();
      return ins;
   endfunction

   function automatic int ref_latency(input logic [31:0] ins);
      ctl_t e, m;
      ref_decode(ins, e, m);
      if (!e.is_muldiv) return 0;
      return ins[14] ? DIV_LAT : MUL_LAT;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 0; in_valid = 0; out_ready = 0;
      #3;
      checks++;
      if (out_valid !== 1'b0 || rd_wen !== 1'b0 || mdu_busy !== 1'b0 || illegal !== 1'b0 || out_instr !== 32'h0)
         $display("FAIL reset_state: out_valid=%b rd_wen=%b mdu_busy=%b illegal=%b out_instr=%h, want all 0",
                  out_valid, rd_wen, mdu_busy, illegal, out_instr);
      else passed++;
      tick(); tick();
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL reset_empty: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
      else passed++;
   endtask

   task automatic test_reset_mid_full();
      in_instr = 32'h003100B3; in_pc = 32'h100; in_valid = 1; out_ready = 0;
      tick();
      in_valid = 0;
      checks++;
      if (out_valid !== 1'b1 || rd_wen !== 1'b1)
         $display("FAIL pre_reset_full: out_valid=%b rd_wen=%b, want 1/1", out_valid, rd_wen);
      else passed++;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || rd_wen !== 1'b0 || out_instr !== 32'h0)
         $display("FAIL async_reset: out_valid=%b rd_wen=%b out_instr=%h, want 0/0/0", out_valid, rd_wen, out_instr);
      else passed++;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_decode_random();
      ctl_t e, m;
      logic [31:0] ins, pc;
      int lat, cyc;
      for (int n = 0; n < 80; n++) begin
         ins = gen_instr(); pc = $urandom();
         ref_decode(ins, e, m);
         lat = ref_latency(ins);
         in_instr = ins; in_pc = pc; in_valid = 1; out_ready = 1;
         tick();
         in_valid = 0;
         cyc = 0;
         while (out_valid !== 1'b1 && cyc < 60) begin tick(); cyc++; end
         checks++;
         if (cyc != lat)
            $display("FAIL decode_latency: instr=%h got %0d cycles, want %0d", ins, cyc, lat);
         else passed++;
         checks++;
         if ((obs & m) !== (e & m) || out_instr !== ins || out_pc !== pc || out_funct3 !== ins[14:12])
            $display("FAIL decode_bundle: instr=%h got ctl=%h instr=%h pc=%h, want ctl=%h (mask %h) pc=%h",
                     ins, obs, out_instr, out_pc, e, m, pc);
         else passed++;
         tick();
         checks++;
         if (out_valid !== 1'b0)
            $display("FAIL decode_drain: out_valid=%b, want 0", out_valid);
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      in_instr = 32'h003100B3; in_pc = 32'h200; in_valid = 1; out_ready = 1;
      tick();
      in_instr = 32'h403100B3; in_pc = 32'h204;
      #1;
      checks++;
      if (out_valid !== 1'b1 || alu_op !== 4'd0 || rd_wen !== 1'b1 || illegal !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL b2b_add: out_valid=%b alu_op=%0d rd_wen=%b illegal=%b in_ready=%b, want 1/0/1/0/1",
                  out_valid, alu_op, rd_wen, illegal, in_ready);
      else passed++;
      tick();
      in_valid = 0;
      checks++;
      if (out_valid !== 1'b1 || alu_op !== 4'd1 || out_instr !== 32'h403100B3 || out_pc !== 32'h204)
         $display("FAIL b2b_sub: out_valid=%b alu_op=%0d instr=%h pc=%h, want 1/1/403100b3/204",
                  out_valid, alu_op, out_instr, out_pc);
      else passed++;
      tick();
      checks++;
      if (out_valid !== 1'b0)
         $display("FAIL b2b_drain: out_valid=%b, want 0", out_valid);
      else passed++;
   endtask

   task automatic test_stall();
      in_instr = 32'h0020A023; in_pc = 32'h300; in_valid = 1; out_ready = 0;
      tick();
      in_instr = 32'h003100B3; in_pc = 32'h304;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (out_valid !== 1'b1 || mem_wr !== 1'b1 || imm_sel !== 3'd1 || in_ready !== 1'b0 ||
             out_instr !== 32'h0020A023)
            $display("FAIL stall_hold: cyc=%0d out_valid=%b mem_wr=%b imm_sel=%0d in_ready=%b instr=%h, want 1/1/1/0/0020a023",
                     i, out_valid, mem_wr, imm_sel, in_ready, out_instr);
         else passed++;
         tick();
      end
      out_ready = 1;
      tick();
      in_valid = 0;
      checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'h003100B3 || out_pc !== 32'h304)
         $display("FAIL stall_release: out_valid=%b instr=%h pc=%h, want 1/003100b3/304", out_valid, out_instr, out_pc);
      else passed++;
      tick();
   endtask

   task automatic test_illegal();
      logic [31:0] cases [2];
      cases = '{32'h0000007F, 32'h403170B3};
      for (int i = 0; i < 2; i++) begin
         in_instr = cases[i]; in_pc = 32'h400 + 32'(i * 4); in_valid = 1; out_ready = 1;
         tick();
         in_valid = 0;
         checks++;
         if (out_valid !== 1'b1 || illegal !== 1'b1 || rd_wen !== 1'b0 || mem_rd !== 1'b0 ||
             mem_wr !== 1'b0 || branch !== 1'b0 || jump !== 1'b0 || is_muldiv !== 1'b0)
            $display("FAIL illegal_bundle: instr=%h out_valid=%b illegal=%b en=%b%b%b%b%b%b, want 1/1/000000",
                     cases[i], out_valid, illegal, rd_wen, mem_rd, mem_wr, branch, jump, is_muldiv);
         else passed++;
         tick();
      end
   endtask

   task automatic test_muldiv();
      int cyc, busy;
      in_instr = 32'h0220C0B3; in_pc = 32'h500; in_valid = 1; out_ready = 1;
      tick();
      in_valid = 0;
      if (M_EN) begin
         cyc = 0; busy = 0;
         while (out_valid !== 1'b1 && cyc < 60) begin
            if (mdu_busy === 1'b1) busy++;
            tick(); cyc++;
         end
         checks++;
         if (cyc != DIV_LAT || busy != DIV_LAT)
            $display("FAIL div_latency: valid after %0d busy %0d, want %0d/%0d", cyc, busy, DIV_LAT, DIV_LAT);
         else passed++;
         checks++;
         if (is_muldiv !== 1'b1 || out_funct3 !== 3'b100 || rd_wen !== 1'b1 || mdu_busy !== 1'b0)
            $display("FAIL div_bundle: is_muldiv=%b funct3=%b rd_wen=%b mdu_busy=%b, want 1/100/1/0",
                     is_muldiv, out_funct3, rd_wen, mdu_busy);
         else passed++;
      end else begin
         checks++;
         if (out_valid !== 1'b1 || illegal !== 1'b1 || is_muldiv !== 1'b0 || mdu_busy !== 1'b0)
            $display("FAIL div_disabled: out_valid=%b illegal=%b is_muldiv=%b mdu_busy=%b, want 1/1/0/0",
                     out_valid, illegal, is_muldiv, mdu_busy);
         else passed++;
      end
      tick();
   endtask

   task automatic test_flush();
      bit seen;
      for (int k = 0; k < 2; k++) begin
         if (k == 0 && !M_EN) continue;
         in_instr = (k == 0) ? 32'h0220C0B3 : 32'h003100B3;
         in_pc = 32'h600; in_valid = 1; out_ready = (k == 0);
         tick();
         in_valid = 0;
         repeat (3) tick();
         flush = 1; in_valid = 1; in_instr = 32'h403100B3; in_pc = 32'h604;
         #1;
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL flush_same_cycle: k=%0d out_valid=%b in_ready=%b, want 0/0", k, out_valid, in_ready);
         else passed++;
         tick();
         flush = 0; in_valid = 0; out_ready = 1;
         #1;
         checks++;
         if (out_valid !== 1'b0 || mdu_busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_empty: k=%0d out_valid=%b mdu_busy=%b in_ready=%b, want 0/0/1",
                     k, out_valid, mdu_busy, in_ready);
         else passed++;
         seen = 0;
         repeat (40) begin tick(); if (out_valid !== 1'b0) seen = 1; end
         checks++;
         if (seen)
            $display("FAIL flush_discard: k=%0d out_valid rose after flush, want stays 0", k);
         else passed++;
      end
   endtask

   task automatic test_stream();
      logic [31:0] q_ins[$], q_pc[$];
      logic [31:0] ei, ep;
      ctl_t e, m;
      bit fire_in, fire_out;
      int guard;
      for (int c = 0; c < 600; c++) begin
         in_valid = ($urandom_range(0, 2) != 0);
         in_instr = gen_instr(); in_pc = $urandom();
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         fire_in = in_valid && in_ready;
         fire_out = out_valid && out_ready;
         if (fire_out) begin
            checks++;
            if (q_ins.size() == 0) begin
               $display("FAIL stream_spurious: out_valid with nothing accepted, instr=%h", out_instr);
            end else begin
               ei = q_ins.pop_front(); ep = q_pc.pop_front();
               ref_decode(ei, e, m);
               if ((obs & m) !== (e & m) || out_instr !== ei || out_pc !== ep)
                  $display("FAIL stream_bundle: got instr=%h pc=%h ctl=%h, want instr=%h pc=%h ctl=%h (mask %h)",
                           out_instr, out_pc, obs, ei, ep, e, m);
               else passed++;
            end
         end
         if (fire_in) begin q_ins.push_back(in_instr); q_pc.push_back(in_pc); end
         tick();
      end
      in_valid = 0; out_ready = 1;
      guard = 0;
      while (q_ins.size() != 0 && guard < 100) begin
         #1;
         if (out_valid === 1'b1) begin
            ei = q_ins.pop_front(); ep = q_pc.pop_front();
            checks++;
            if (out_instr !== ei || out_pc !== ep)
               $display("FAIL stream_drain: got instr=%h pc=%h, want %h/%h", out_instr, out_pc, ei, ep);
            else passed++;
         end
         tick(); guard++;
      end
      checks++;
      if (q_ins.size() != 0)
         $display("FAIL stream_lost: %0d accepted instructions never delivered, want 0", q_ins.size());
      else passed++;
   endtask

   initial begin
      test_reset();
      test_reset_mid_full();
      test_back_to_back();
      test_stall();
      test_illegal();
      test_muldiv();
      test_flush();
      test_decode_random();
      test_stream();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
